// File: rtl/mskaes_host_ctrl.sv
// Host-side controller for the masked AES-128 core: shares inputs, launches one run, recombines
// the result. Optional MSKAES_HOST_ZEROIZE_EN clears share/result registers once consumed.
module mskaes_host_ctrl #(
    parameter int unsigned d       = 2,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [127:0]           in_plaintext,
    input  logic [127:0]           in_key,
    input  logic [256*(d-1)-1:0]   rnd_share,
    output logic                   core_valid_in,
    input  logic                   core_ready,
    output logic [128*d-1:0]       core_sh_plaintext,
    output logic [128*d-1:0]       core_sh_key,
    input  logic                   core_cipher_valid,
    input  logic [128*d-1:0]       core_sh_ciphertext,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [127:0]           out_ciphertext,
    output logic [15:0]            out_cycles,
    output logic                   out_timeout
);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StIssue  = 2'd1;
    localparam logic [1:0] StWait   = 2'd2;
    localparam logic [1:0] StOutput = 2'd3;

    localparam int unsigned Dm1        = d - 1;
    localparam logic [15:0] TimeoutVal = 16'(TIMEOUT);

    logic [1:0]         state_q, state_d;
    logic [128*d-1:0]   sh_pt_q, sh_pt_d, sh_key_q, sh_key_d;
    logic [128*d-1:0]   sh_pt, sh_key;
    logic [15:0]        cnt_q, cnt_d;
    logic [127:0]       ct_q, ct_d, ct_rec;
    logic [15:0]        cyc_q, cyc_d;
    logic               to_q, to_d;
    logic               acc_pt, acc_key;

    // Bit i share j sits at d*i+j; the last share absorbs the data bit.
    always_comb begin
        sh_pt   = '0;
        sh_key  = '0;
        acc_pt  = 1'b0;
        acc_key = 1'b0;
        for (int unsigned i = 0; i < 128; i++) begin
            acc_pt  = in_plaintext[i];
            acc_key = in_key[i];
            for (int unsigned j = 0; j < Dm1; j++) begin
                sh_pt[d*i+j]  = rnd_share[i*Dm1+j];
                sh_key[d*i+j] = rnd_share[128*Dm1+i*Dm1+j];
                acc_pt        = acc_pt ^ rnd_share[i*Dm1+j];
                acc_key       = acc_key ^ rnd_share[128*Dm1+i*Dm1+j];
            end
            sh_pt[d*i+Dm1]  = acc_pt;
            sh_key[d*i+Dm1] = acc_key;
        end
    end

    always_comb begin
        ct_rec = '0;
        for (int unsigned i = 0; i < 128; i++) begin
            ct_rec[i] = ^core_sh_ciphertext[d*i +: d];
        end
    end

    always_comb begin
        state_d  = state_q;
        sh_pt_d  = sh_pt_q;
        sh_key_d = sh_key_q;
        cnt_d    = cnt_q;
        ct_d     = ct_q;
        cyc_d    = cyc_q;
        to_d     = to_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    sh_pt_d  = sh_pt;
                    sh_key_d = sh_key;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (core_ready) begin
                    cnt_d   = 16'd1;
                    state_d = StWait;
`ifdef MSKAES_HOST_ZEROIZE_EN
                    sh_pt_d  = '0;
                    sh_key_d = '0;
`endif
                end
            end
            StWait: begin
                cnt_d = (cnt_q == 16'hffff) ? cnt_q : cnt_q + 16'd1;
                // A result arriving on the timeout cycle still counts as a valid run.
                if (core_cipher_valid) begin
                    ct_d    = ct_rec;
                    cyc_d   = cnt_q;
                    to_d    = 1'b0;
                    state_d = StOutput;
                end else if (cnt_q == TimeoutVal) begin
                    ct_d    = '0;
                    cyc_d   = TimeoutVal;
                    to_d    = 1'b1;
                    state_d = StOutput;
                end
            end
            StOutput: begin
                if (out_ready) begin
                    state_d = StIdle;
`ifdef MSKAES_HOST_ZEROIZE_EN
                    ct_d  = '0;
                    cyc_d = '0;
`endif
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q  <= StIdle;
            sh_pt_q  <= '0;
            sh_key_q <= '0;
            cnt_q    <= '0;
            ct_q     <= '0;
            cyc_q    <= '0;
            to_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            sh_pt_q  <= sh_pt_d;
            sh_key_q <= sh_key_d;
            cnt_q    <= cnt_d;
            ct_q     <= ct_d;
            cyc_q    <= cyc_d;
            to_q     <= to_d;
        end
    end

    assign in_ready          = (state_q == StIdle);
    assign core_valid_in     = (state_q == StIssue) && core_ready;
    assign out_valid         = (state_q == StOutput);
    assign core_sh_plaintext = sh_pt_q;
    assign core_sh_key       = sh_key_q;
    assign out_ciphertext    = ct_q;
    assign out_cycles        = cyc_q;
    assign out_timeout       = to_q;

endmodule
